stress_sensor_array: RTL and testbench



---
 rtl/stress_pkg.sv | 13 +
 rtl/stress_debounce.sv | 47 ++++
 rtl/stress_sensor_array.sv | 133 +++++++++++++
 tb/tb_stress_sensor_array.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/stress_pkg.sv
// Shared types for the stress sensor array: FSM state encoding.
package stress_pkg;

    localparam int STATE_W = 2;

    // Classification states; 2'b11 is never produced.
    typedef enum logic [STATE_W-1:0] {
        ST_CALM     = 2'b00,
        ST_ALERT    = 2'b01,
        ST_STRESSED = 2'b10
    } stress_state_e;

endpackage

// File: rtl/stress_debounce.sv
// One sensor channel: two-flop synchroniser followed by a counter debouncer.
// The debounced bit only follows the synchronised input after DEB_CYCLES
// consecutive samples that disagree with it.
module stress_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sensor,
    output logic deb
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous level into the clk domain.
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= sensor;
            s2 <= s1;
        end
    end

    // Count consecutive disagreeing samples; flip deb on the DEB_CYCLES-th one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            deb <= 1'b0;
        end else if (s2 == deb) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            deb <= s2;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/stress_sensor_array.sv
// Multi-channel stress sensor: debounced, enable-masked channels feed a
// saturating leaky score, which a three-state FSM with a minimum hold time
// in STRESSED classifies.
module stress_sensor_array
    import stress_pkg::*;
#(
    parameter int N_CH        = 8,
    parameter int DEB_CYCLES  = 4,
    parameter int SCORE_W     = 8,
    parameter int ALERT_TH    = 16,
    parameter int STRESS_TH   = 64,
    parameter int HOLD_CYCLES = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_CH-1:0]    sensor,
    input  logic [N_CH-1:0]    ch_en,
    output logic [N_CH-1:0]    active,
    output logic [SCORE_W-1:0] score,
    output logic [STATE_W-1:0] state,
    output logic               response
);

    localparam int CNT_W  = $clog2(N_CH + 1);
    localparam int SUM_W  = SCORE_W + CNT_W;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
    localparam logic [SCORE_W-1:0] ALERT_LVL  = SCORE_W'(ALERT_TH);
    localparam logic [SCORE_W-1:0] STRESS_LVL = SCORE_W'(STRESS_TH);
    localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_CYCLES - 1);

    logic [N_CH-1:0]    deb;
    logic [CNT_W-1:0]   n_active;
    logic [SUM_W-1:0]   score_sum;
    logic [SCORE_W-1:0] score_next;
    logic [SCORE_W-1:0] score_q;
    stress_state_e      state_q;
    logic [HOLD_W-1:0]  hold_q;
    logic               response_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        stress_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .sensor(sensor[i]),
            .deb   (deb[i])
        );
    end

    // Masking is combinational so a disabled channel drops out at once.
    assign active = deb & ch_en;

    // Number of active channels this cycle.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        n_active = '0;
        for (int i = 0; i < N_CH; i++) begin
            n_active = n_active + CNT_W'(active[i]);
        end
    end

    // Rise by the active count with saturation, otherwise leak by one down to zero.
    always_comb begin
        score_sum  = SUM_W'(score_q) + SUM_W'(n_active);
        score_next = score_q;
        if (n_active != '0) begin
            score_next = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : score_sum[SCORE_W-1:0];
        end else if (score_q != '0) begin
            score_next = score_q - 1'b1;
        end
    end

    // Score register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_q <= '0;
        end else begin
            score_q <= score_next;
        end
    end

    // Classify the registered score; STRESSED is held for at least HOLD_CYCLES.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_CALM;
            hold_q     <= '0;
            response_q <= 1'b0;
        end else begin
            case (state_q)
                ST_CALM: begin
                    if (score_q >= STRESS_LVL) begin
                        state_q    <= ST_STRESSED;
                        hold_q     <= HOLD_LOAD;
                        response_q <= 1'b1;
                    end else if (score_q >= ALERT_LVL) begin
                        state_q <= ST_ALERT;
                    end
                end
                ST_ALERT: begin
                    if (score_q >= STRESS_LVL) begin
                        state_q    <= ST_STRESSED;
                        hold_q     <= HOLD_LOAD;
                        response_q <= 1'b1;
                    end else if (score_q < ALERT_LVL) begin
                        state_q <= ST_CALM;
                    end
                end
                ST_STRESSED: begin
                    // Re-crossing the threshold here never reloads the hold timer.
                    if (hold_q == '0 && score_q < STRESS_LVL) begin
                        state_q    <= (score_q >= ALERT_LVL) ? ST_ALERT : ST_CALM;
                        response_q <= 1'b0;
                    end else if (hold_q != '0) begin
                        hold_q <= hold_q - 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_CALM;
                    hold_q     <= '0;
                    response_q <= 1'b0;
                end
            endcase
        end
    end

    assign score    = score_q;
    assign state    = state_q;
    assign response = response_q;

endmodule

// File: tb/tb_stress_sensor_array.sv
// Directed bench for stress_sensor_array with a cycle-level reference model.
module tb_stress_sensor_array;

    localparam int N_CH      = 8;
    localparam int DEB       = 4;
    localparam int SCORE_MAX = 255;
    localparam int ALERT_TH  = 16;
    localparam int STRESS_TH = 64;
    localparam int HOLD      = 32;

    localparam int M_CALM     = 0;
    localparam int M_ALERT    = 1;
    localparam int M_STRESSED = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N_CH-1:0] sensor = '0;
    logic [N_CH-1:0] ch_en = '0;
    logic [N_CH-1:0] active;
    logic [7:0]      score;
    logic [1:0]      state;
    logic            response;

    int n_checks = 0;
    int n_errors = 0;

    stress_sensor_array #(
        .N_CH(N_CH), .DEB_CYCLES(DEB), .SCORE_W(8),
        .ALERT_TH(ALERT_TH), .STRESS_TH(STRESS_TH), .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sensor(sensor), .ch_en(ch_en),
        .active(active), .score(score), .state(state), .response(response)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: debounced level, score and classification derived from
    // the behavioural rules (sample history, integer score, time-in-state).
    logic [N_CH-1:0] m_deb;
    logic [N_CH-1:0] m_samp [0:DEB+1];  // m_samp[k]: sensor as sampled k edges ago
    int              m_score;
    int              m_state;
    int              m_age;             // edges spent in STRESSED including entry

    initial begin : model
        logic [N_CH-1:0] act;
        int              n;
        bit              flip;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_deb   = '0;
                m_score = 0;
                m_state = M_CALM;
                m_age   = 0;
                for (int k = 0; k <= DEB + 1; k++) m_samp[k] = '0;
            end else begin
                act = m_deb & ch_en;
                n   = $countones(act);
                case (m_state)
                    M_CALM: begin
                        if (m_score >= STRESS_TH) begin m_state = M_STRESSED; m_age = 1; end
                        else if (m_score >= ALERT_TH) m_state = M_ALERT;
                    end
                    M_ALERT: begin
                        if (m_score >= STRESS_TH) begin m_state = M_STRESSED; m_age = 1; end
                        else if (m_score < ALERT_TH) m_state = M_CALM;
                    end
                    default: begin
                        if (m_age >= HOLD && m_score < STRESS_TH)
                            m_state = (m_score >= ALERT_TH) ? M_ALERT : M_CALM;
                        else
                            m_age++;
                    end
                endcase
                if (n > 0) m_score = (m_score + n > SCORE_MAX) ? SCORE_MAX : m_score + n;
                else if (m_score > 0) m_score--;
                for (int k = DEB + 1; k > 0; k--) m_samp[k] = m_samp[k-1];
                m_samp[0] = sensor;
                // The synchronised value seen at this edge is the sample from two edges ago;
                // a bit flips once DEB consecutive such samples all disagree with it.
                for (int i = 0; i < N_CH; i++) begin
                    flip = 1'b1;
                    for (int j = 0; j < DEB; j++)
                        if (m_samp[2+j][i] == m_deb[i]) flip = 1'b0;
                    if (flip) m_deb[i] = ~m_deb[i];
                end
                #1;
                if (rst_n) begin
                    check("model_active", active, m_deb & ch_en);
                    check("model_score", score, m_score);
                    check("model_state", state, m_state);
                    check("model_response", response, m_state == M_STRESSED);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bit found;
        int cnt;

        // Reset state
        rst_n = 1'b0; sensor = '0; ch_en = 8'hFF;
        #12;
        check("rst_score", score, 0);
        check("rst_state", state, 0);
        check("rst_response", response, 0);
        check("rst_active", active, 0);
        @(negedge clk); rst_n = 1'b1;

        // Three-cycle glitch is rejected
        @(negedge clk); sensor = 8'h01;
        repeat (3) @(negedge clk);
        sensor = '0;
        repeat (10) @(negedge clk);
        check("glitch_active", active, 0);
        check("glitch_score", score, 0);

        // Four-cycle pulse passes, active rises exactly 6 edges after the input edge
        sensor = 8'h01;
        for (int e = 1; e <= 7; e++) begin
            @(posedge clk); #1;
            if (e < 6) check("pulse_active_early", active[0], 0);
            if (e == 6) check("pulse_active_edge6", active[0], 1);
            if (e == 7) check("pulse_score_edge7", score, 1);
            if (e == 4) begin @(negedge clk); sensor = '0; end
        end
        repeat (20) @(negedge clk);
        check("pulse_decayed", score, 0);

        // Ramp with two channels: +2 per cycle
        sensor = 8'h03; ch_en = 8'hFF;
        found = 0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(posedge clk); #1;
            if (state == 2'b01) found = 1;
        end
        check("ramp_alert_seen", found, 1);
        check("ramp_alert_score", score, 18);
        found = 0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(posedge clk); #1;
            if (state == 2'b10) found = 1;
        end
        check("ramp_stressed_seen", found, 1);
        check("ramp_stressed_score", score, 66);
        check("ramp_response", response, 1);

        // Hold: release at once, STRESSED lasts exactly HOLD cycles
        @(negedge clk); sensor = '0;
        cnt = 1;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (state != 2'b10) break;
            cnt++;
        end
        check("hold_cycles", cnt, HOLD);
        check("hold_exit_alert", state, 1);
        check("hold_exit_response", response, 0);
        found = 0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(posedge clk); #1;
            if (state == 2'b00) found = 1;
        end
        check("hold_calm_seen", found, 1);
        check("hold_calm_score", score, 14);
        repeat (40) @(negedge clk);
        check("floor_score", score, 0);

        // Saturation with all channels active
        sensor = 8'hFF;
        repeat (46) @(negedge clk);
        check("sat_score", score, 255);
        check("sat_state", state, 2);
        sensor = '0;
        for (int e = 1; e <= 7; e++) begin
            @(posedge clk); #1;
            if (e == 6) check("sat_hold_255", score, 255);
            if (e == 7) check("sat_first_decay", score, 254);
        end
        repeat (300) @(negedge clk);
        check("decay_floor", score, 0);
        check("decay_calm", state, 0);

        // Masking
        ch_en = 8'h00; sensor = 8'hFF;
        repeat (10) @(negedge clk);
        check("mask_active", active, 0);
        check("mask_score", score, 0);
        ch_en = 8'h01;
        #1;
        check("unmask_active_now", active, 8'h01);
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk); #1;
            if (e == 1) check("unmask_score1", score, 1);
            if (e == 5) check("unmask_score5", score, 5);
            if (e == 40) check("unmask_score40", score, 40);
        end

        // Asynchronous reset mid-run with score 40
        #2; rst_n = 1'b0;
        #1;
        check("midrst_score", score, 0);
        check("midrst_state", state, 0);
        check("midrst_response", response, 0);
        check("midrst_active", active, 0);
        @(negedge clk); rst_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk); #1;
            if (e == 5) check("postrst_active_edge5", active, 0);
            if (e == 6) check("postrst_active_edge6", active, 8'h01);
        end
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
